// File: rtl/mio_cli_pkg.sv
// rtl/mio_cli_pkg.sv - opcode/state types, opcode constants and parity helper for the mio_cli responder
package mio_cli_pkg;

    localparam logic [1:0] MIO_CLI_OP_NOP     = 2'd0;
    localparam logic [1:0] MIO_CLI_OP_READ    = 2'd1;
    localparam logic [1:0] MIO_CLI_OP_WRITE   = 2'd2;
    localparam logic [1:0] MIO_CLI_OP_ILLEGAL = 2'd3;

    // Widest command vector the parity helper accepts; narrower vectors are zero-extended,
    // which does not change their parity.
    localparam int MIO_CLI_PAR_MAX_W = 256;

    typedef enum logic [1:0] {
        OP_NOP     = MIO_CLI_OP_NOP,
        OP_READ    = MIO_CLI_OP_READ,
        OP_WRITE   = MIO_CLI_OP_WRITE,
        OP_ILLEGAL = MIO_CLI_OP_ILLEGAL
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Even parity: the returned bit makes the total number of ones even.
    function automatic logic mio_cli_parity(input logic [MIO_CLI_PAR_MAX_W-1:0] bits);
        return ^bits;
    endfunction

endpackage

// File: rtl/uvma_mio_cli_rsp_regfile.sv
// rtl/uvma_mio_cli_rsp_regfile.sv - NUM_REGS x DATA_WIDTH register file, sync write, comb read, sync clear
module uvma_mio_cli_rsp_regfile #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REGS   = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);

    logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
    logic                  addr_ok;

    // Unimplemented indices read as zero; the caller never writes them.
    assign addr_ok = {1'b0, addr_i} < NUM_REGS_W;

    // Storage: cleared on reset, written when enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && addr_ok) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Combinational read port.
    always_comb begin
        rdata_o = '0;
        if (addr_ok) begin
            rdata_o = mem_q[addr_i];
        end
    end

endmodule

// File: rtl/uvma_mio_cli_rsp.sv
// rtl/uvma_mio_cli_rsp.sv - mio_cli responder: FSM, latency counter, regfile access; option MIO_CLI_RSP_PARITY_EN
module uvma_mio_cli_rsp
    import mio_cli_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 4,
    parameter int NUM_REGS    = 16,
    parameter int RSP_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_opcode,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
`ifdef MIO_CLI_RSP_PARITY_EN
    input  logic                  req_parity,
`endif
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err
);

    localparam logic [ADDR_WIDTH:0] NUM_REGS_W = (ADDR_WIDTH+1)'(NUM_REGS);
    // WAIT lasts RSP_LATENCY cycles, so the counter starts one below the latency.
    localparam logic [7:0] LAT_INIT = (RSP_LATENCY == 0) ? 8'd0 : 8'(RSP_LATENCY - 1);

    state_t                state_q, state_d;
    logic [7:0]            cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  err_q, err_d;

    opcode_t               op;
    logic                  accept;
    logic                  rsp_hs;
    logic                  addr_oob;
    logic                  par_err;
    logic                  cmd_err;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] rf_rdata;

    assign op       = opcode_t'(req_opcode);
    assign accept   = req_valid & req_ready;
    assign rsp_hs   = rsp_valid & rsp_ready;
    assign addr_oob = {1'b0, req_addr} >= NUM_REGS_W;

`ifdef MIO_CLI_RSP_PARITY_EN
    assign par_err = req_parity != mio_cli_parity(MIO_CLI_PAR_MAX_W'({req_opcode, req_addr, req_wdata}));
`else
    assign par_err = 1'b0;
`endif

    // Classify the presented command; an erroring command never touches state.
    always_comb begin
        cmd_err = 1'b0;
        case (op)
            OP_NOP:            cmd_err = par_err;
            OP_READ, OP_WRITE: cmd_err = addr_oob | par_err;
            default:           cmd_err = 1'b1;
        endcase
    end

    // WRITE commits on the accept edge; READ sees the pre-edge contents.
    assign wr_en = accept && (op == OP_WRITE) && !cmd_err;

    uvma_mio_cli_rsp_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .NUM_REGS   (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_en),
        .addr_i  (req_addr),
        .wdata_i (req_wdata),
        .rdata_o (rf_rdata)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: IDLE -> WAIT -> RESP -> IDLE, WAIT skipped at zero latency.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (RSP_LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 8'd0) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_hs) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE out of reset, response gated to RESP.
    always_comb begin
        req_ready = (state_q == IDLE) && !reset;
        rsp_valid = (state_q == RESP);
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err   = rsp_valid & err_q;
    end

    // Next values for the latency counter and the captured response.
    always_comb begin
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        if (accept) begin
            cnt_d   = LAT_INIT;
            err_d   = cmd_err;
            rdata_d = ((op == OP_READ) && !cmd_err) ? rf_rdata : '0;
        end else if ((state_q == WAIT) && (cnt_q != 8'd0)) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Latency counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= 8'd0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_uvma_mio_cli_rsp.sv
// tb/tb_uvma_mio_cli_rsp.sv - self-checking bench: default instance and a 12-reg zero-latency instance
module tb_uvma_mio_cli_rsp;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk;
    logic          reset      [2];
    logic          req_valid  [2];
    logic          req_ready  [2];
    logic [1:0]    req_opcode [2];
    logic [AW-1:0] req_addr   [2];
    logic [DW-1:0] req_wdata  [2];
    logic          rsp_valid  [2];
    logic          rsp_ready  [2];
    logic [DW-1:0] rsp_rdata  [2];
    logic          rsp_err    [2];
`ifdef MIO_CLI_RSP_PARITY_EN
    logic          req_parity [2];
`endif

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int cyc    = 0;

    uvma_mio_cli_rsp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(16), .RSP_LATENCY(2)) u_dut_a (
        .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_opcode(req_opcode[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
`ifdef MIO_CLI_RSP_PARITY_EN
        .req_parity(req_parity[0]),
`endif
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    uvma_mio_cli_rsp #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(12), .RSP_LATENCY(0)) u_dut_b (
        .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_opcode(req_opcode[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
`ifdef MIO_CLI_RSP_PARITY_EN
        .req_parity(req_parity[1]),
`endif
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nregs(input int i);
        return (i == 0) ? 16 : 12;
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s timed out t=%0t", nm, $time);
    endtask

    // Reference model: a pending response with a due cycle, plus a register array per instance.
    bit            m_pend [2];
    int            m_due  [2];
    logic [DW-1:0] m_data [2];
    bit            m_err  [2];
    logic [DW-1:0] m_mem  [2][16];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0;
            m_due[i]  = 0;
            m_data[i] = '0;
            m_err[i]  = 0;
            for (int a = 0; a < 16; a++) m_mem[i][a] = '0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit vnow;
            bit e;
            int op;
            int ad;
            vnow = m_pend[i] && (cyc >= m_due[i]);
            op   = int'(req_opcode[i]);
            ad   = int'(req_addr[i]);
            if (reset[i]) begin
                m_pend[i] = 0;
                for (int a = 0; a < 16; a++) m_mem[i][a] = '0;
            end else if (m_pend[i]) begin
                if (vnow && rsp_ready[i]) m_pend[i] = 0;
            end else if (req_valid[i]) begin
                e = (op == 3) || ((op == 1 || op == 2) && ad >= nregs(i));
`ifdef MIO_CLI_RSP_PARITY_EN
                if (req_parity[i] != ^{req_opcode[i], req_addr[i], req_wdata[i]}) e = 1;
`endif
                m_err[i]  = e;
                m_data[i] = (op == 1 && !e) ? m_mem[i][ad] : '0;
                if (op == 2 && !e) m_mem[i][ad] = req_wdata[i];
                m_pend[i] = 1;
                m_due[i]  = cyc + 1 + lat_of(i);
            end
        end
        cyc = cyc + 1;
    end

    // Compare every cycle, mid-period, against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                bit exp_rv;
                bit exp_rr;
                exp_rv = m_pend[i] && (cyc >= m_due[i]);
                exp_rr = !m_pend[i] && !reset[i];
                chk((i == 0) ? "a.req_ready" : "b.req_ready", DW'(req_ready[i]), DW'(exp_rr));
                chk((i == 0) ? "a.rsp_valid" : "b.rsp_valid", DW'(rsp_valid[i]), DW'(exp_rv));
                if (exp_rv) begin
                    chk((i == 0) ? "a.rsp_rdata" : "b.rsp_rdata", rsp_rdata[i], m_data[i]);
                    chk((i == 0) ? "a.rsp_err" : "b.rsp_err", DW'(rsp_err[i]), DW'(m_err[i]));
                end
            end
        end
    end

    task automatic set_cmd(input int i, input logic [1:0] op, input logic [AW-1:0] ad,
                           input logic [DW-1:0] wd, input bit par_ok);
        req_opcode[i] = op;
        req_addr[i]   = ad;
        req_wdata[i]  = wd;
`ifdef MIO_CLI_RSP_PARITY_EN
        req_parity[i] = (^{op, ad, wd}) ^ !par_ok;
`endif
    endtask

    // Holds req_valid until accepted; returns just after the accept edge.
    task automatic wait_accept(input int i, output bit ok);
        int n;
        ok = 0;
        n  = 0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = req_ready[i];
            @(posedge clk); #1;
            n++;
        end
        req_valid[i] = 0;
        if (!ok) fail_now("accept");
    endtask

    // Returns at the first negedge showing rsp_valid; lat counts negedges since the accept edge.
    task automatic wait_valid(input int i, output bit ok, output int lat);
        ok  = 0;
        lat = 0;
        while (lat < 300) begin
            @(negedge clk);
            lat++;
            if (rsp_valid[i]) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) fail_now("rsp_valid");
    endtask

    task automatic do_txn(input int i, input logic [1:0] op, input logic [AW-1:0] ad,
                          input logic [DW-1:0] wd, input bit par_ok,
                          output logic [DW-1:0] rd, output logic er, output int lat);
        bit ok;
        set_cmd(i, op, ad, wd, par_ok);
        req_valid[i] = 1;
        rsp_ready[i] = 1;
        rd  = '0;
        er  = 0;
        lat = 0;
        wait_accept(i, ok);
        if (ok) begin
            wait_valid(i, ok, lat);
            rd = rsp_rdata[i];
            er = rsp_err[i];
        end
        @(posedge clk); #1;
        rsp_ready[i] = 0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [DW-1:0] rd;
        logic          er;
        int            lat;
        bit            ok;
        int            acc [4];
        int            rv  [4];
        int            k;
        int            r;
        int            n;
        bit            acc_now;

        for (int i = 0; i < 2; i++) begin
            reset[i]     = 1;
            req_valid[i] = 0;
            rsp_ready[i] = 0;
            set_cmd(i, 2'd0, '0, '0, 1);
        end
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst.req_ready_a", DW'(req_ready[0]), DW'(0));
        chk("rst.req_ready_b", DW'(req_ready[1]), DW'(0));
        chk("rst.rsp_valid_a", DW'(rsp_valid[0]), DW'(0));
        chk("rst.rsp_rdata_a", rsp_rdata[0], '0);
        chk("rst.rsp_err_a", DW'(rsp_err[0]), DW'(0));
        @(posedge clk); #1;
        reset[0] = 0;
        reset[1] = 0;
        chk_en = 1;
        @(negedge clk);
        chk("post_rst.req_ready_a", DW'(req_ready[0]), DW'(1));
        @(posedge clk); #1;

        // WRITE then READ at the default latency.
        do_txn(0, 2'd2, 4'd3, 32'hDEADBEEF, 1, rd, er, lat);
        chk("t1.wr_err", DW'(er), DW'(0));
        chk("t1.wr_lat", DW'(lat), DW'(3));
        do_txn(0, 2'd1, 4'd3, 32'h0, 1, rd, er, lat);
        chk("t1.rd_data", rd, 32'hDEADBEEF);
        chk("t1.rd_err", DW'(er), DW'(0));
        chk("t1.rd_lat", DW'(lat), DW'(3));

        // READ of a never-written register held in RESP by rsp_ready low.
        set_cmd(0, 2'd1, 4'd5, 32'h0, 1);
        req_valid[0] = 1;
        rsp_ready[0] = 0;
        wait_accept(0, ok);
        wait_valid(0, ok, lat);
        for (int j = 0; j < 10; j++) begin
            chk("t2.rsp_valid", DW'(rsp_valid[0]), DW'(1));
            chk("t2.rsp_rdata", rsp_rdata[0], '0);
            chk("t2.req_ready", DW'(req_ready[0]), DW'(0));
            @(posedge clk); #1;
            @(negedge clk);
        end
        rsp_ready[0] = 1;
        @(posedge clk); #1;
        rsp_ready[0] = 0;
        @(negedge clk);
        chk("t2.ready_after", DW'(req_ready[0]), DW'(1));
        chk("t2.valid_after", DW'(rsp_valid[0]), DW'(0));
        @(posedge clk); #1;

        // Out-of-range and illegal commands on the 12-register instance.
        do_txn(1, 2'd2, 4'd13, 32'h55AA55AA, 1, rd, er, lat);
        chk("t3.wr13_err", DW'(er), DW'(1));
        chk("t3.wr13_rdata", rd, '0);
        chk("t3.lat0", DW'(lat), DW'(1));
        do_txn(1, 2'd3, 4'd0, 32'h12345678, 1, rd, er, lat);
        chk("t3.op3_err", DW'(er), DW'(1));
        chk("t3.op3_rdata", rd, '0);
        do_txn(1, 2'd1, 4'd13, 32'h0, 1, rd, er, lat);
        chk("t3.rd13_err", DW'(er), DW'(1));
        do_txn(1, 2'd1, 4'd11, 32'h0, 1, rd, er, lat);
        chk("t3.rd11_err", DW'(er), DW'(0));

        // Back-to-back WRITEs at zero latency with req_valid held high.
        k = 0;
        r = 0;
        n = 0;
        set_cmd(1, 2'd2, 4'd0, 32'hA000_0000, 1);
        req_valid[1] = 1;
        rsp_ready[1] = 1;
        while ((k < 4 || r < 4) && n < 100) begin
            @(negedge clk);
            if (rsp_valid[1] && r < 4) begin
                rv[r] = cyc;
                r++;
            end
            acc_now = req_ready[1] && req_valid[1];
            if (acc_now) begin
                acc[k] = cyc;
                k++;
            end
            @(posedge clk); #1;
            n++;
            if (acc_now) begin
                if (k < 4) set_cmd(1, 2'd2, AW'(k), 32'hA000_0000 + DW'(k), 1);
                else req_valid[1] = 0;
            end
        end
        req_valid[1] = 0;
        rsp_ready[1] = 0;
        if (k < 4 || r < 4) fail_now("t4.accepts");
        else begin
            for (int j = 1; j < 4; j++) chk("t4.spacing", DW'(acc[j] - acc[j-1]), DW'(2));
            for (int j = 0; j < 4; j++) chk("t4.rsp_delay", DW'(rv[j] - acc[j]), DW'(1));
        end
        do_txn(1, 2'd1, 4'd2, 32'h0, 1, rd, er, lat);
        chk("t4.readback", rd, 32'hA000_0002);

        // Reset during WAIT discards the response and clears the registers.
        do_txn(0, 2'd2, 4'd7, 32'h1234_5678, 1, rd, er, lat);
        set_cmd(0, 2'd1, 4'd7, 32'h0, 1);
        req_valid[0] = 1;
        rsp_ready[0] = 1;
        wait_accept(0, ok);
        @(negedge clk);
        chk("t5.wait_no_valid", DW'(rsp_valid[0]), DW'(0));
        @(posedge clk); #1;
        reset[0] = 1;
        @(posedge clk); #1;
        reset[0] = 0;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            chk("t5.no_valid", DW'(rsp_valid[0]), DW'(0));
            @(posedge clk); #1;
        end
        rsp_ready[0] = 0;
        do_txn(0, 2'd1, 4'd7, 32'h0, 1, rd, er, lat);
        chk("t5.rd_after_rst", rd, '0);
        chk("t5.err_after_rst", DW'(er), DW'(0));

`ifdef MIO_CLI_RSP_PARITY_EN
        do_txn(0, 2'd2, 4'd1, 32'h1, 0, rd, er, lat);
        chk("t6.badpar_err", DW'(er), DW'(1));
        chk("t6.badpar_lat", DW'(lat), DW'(3));
        do_txn(0, 2'd1, 4'd1, 32'h0, 1, rd, er, lat);
        chk("t6.rd_unwritten", rd, '0);
        do_txn(0, 2'd2, 4'd1, 32'h1, 1, rd, er, lat);
        chk("t6.goodpar_err", DW'(er), DW'(0));
        do_txn(0, 2'd1, 4'd1, 32'h0, 1, rd, er, lat);
        chk("t6.rd_written", rd, 32'h1);
`endif

        // Randomized traffic on both instances, checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 2; i++) begin
                reset[i]     = ($urandom_range(0, 149) == 0);
                req_valid[i] = ($urandom_range(0, 3) != 0);
                rsp_ready[i] = ($urandom_range(0, 2) != 0);
                set_cmd(i, ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                        AW'($urandom_range(0, 15)), DW'($urandom()),
                        $urandom_range(0, 7) != 0);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 2; i++) begin
            reset[i]     = 0;
            req_valid[i] = 0;
            rsp_ready[i] = 1;
        end
        repeat (10) @(posedge clk);
        #1;
        chk_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
